// File: rtl/spi_ram_burst.sv
// Command-driven RAM with single-word writes and zero-latency burst reads.
// Define SPI_RAM_AUTOINC_EN to advance the addresses after every access.
module spi_ram_burst #(
  parameter int unsigned MEM_WIDTH = 8,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEM_WIDTH+1:0] din,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 cmd_drop
);

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] waddr_q;
  logic [ADDR_SIZE-1:0] raddr_q;
  logic [ADDR_SIZE-1:0] count_q;
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] arg;
  logic                 accept;
  logic                 wr_en;
  logic [MEM_WIDTH-1:0] rd_word;

  assign opcode  = din[MEM_WIDTH+1:MEM_WIDTH];
  assign arg     = din[ADDR_SIZE-1:0];
  assign accept  = rx_valid && !busy;
  assign wr_en   = accept && (opcode == 2'b01) && (32'(waddr_q) < MEM_DEPTH);
  // Addresses beyond the populated depth read as zero.
  assign rd_word = (32'(raddr_q) < MEM_DEPTH) ? mem[raddr_q] : '0;

  function automatic logic [ADDR_SIZE-1:0] adv(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) == MEM_DEPTH - 1) return '0;
    return a + ADDR_SIZE'(1);
  endfunction

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr_q] <= din[MEM_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      cmd_drop <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cmd_drop <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (opcode)
              2'b00: waddr_q <= arg;
              2'b01: begin
                if (AutoInc) waddr_q <= adv(waddr_q);
              end
              2'b10: raddr_q <= arg;
              2'b11: begin
                // First word leaves on the same edge that accepts the command.
                dout     <= rd_word;
                tx_valid <= 1'b1;
                if (AutoInc) raddr_q <= adv(raddr_q);
                if (arg != '0) begin
                  state_q <= StBurst;
                  busy    <= 1'b1;
                  count_q <= arg;
                end
              end
            endcase
          end
        end
        StBurst: begin
          cmd_drop <= rx_valid;
          dout     <= rd_word;
          tx_valid <= 1'b1;
          if (AutoInc) raddr_q <= adv(raddr_q);
          count_q  <= count_q - ADDR_SIZE'(1);
          if (count_q == ADDR_SIZE'(1)) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst: two instances (depth 256 and 200) share one stimulus
// stream; a per-burst reference model predicts every word, busy and cmd_drop.
module tb_spi_ram_burst;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AutoInc = 1'b1;
`else
  localparam bit AutoInc = 1'b0;
`endif

  typedef struct {
    int         stamp;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout_w [2];
  logic       txv_w  [2];
  logic       busy_w [2];
  logic       drop_w [2];

  int   cyc = 0;
  exp_t sb_q [2][$];
  logic [7:0] mem_m [2][256];
  int   wa [2];
  int   ra [2];
  int   b_s = 0;
  int   b_e = 0;
  bit   exp_busy = 0;
  bit   exp_drop = 0;
  bit   exp_rst = 0;
  bit   probe = 0;
  bit   done = 0;
  bit   finished = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_ram_burst u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[0]), .tx_valid(txv_w[0]), .busy(busy_w[0]), .cmd_drop(drop_w[0])
  );

  spi_ram_burst #(.MEM_DEPTH(200)) u_dut200 (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
    .dout(dout_w[1]), .tx_valid(txv_w[1]), .busy(busy_w[1]), .cmd_drop(drop_w[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int adv(input int a, input int depth);
    return (a == depth - 1) ? 0 : (a + 1) % 256;
  endfunction

  // Reference model: applies the command seen at edge number cyc.
  task automatic model_edge(input logic v, input logic [1:0] op, input logic [7:0] arg);
    int   e;
    bit   busy_pre;
    exp_t it;
    e = cyc;
    busy_pre = (e > b_s) && (e <= b_e);
    exp_drop = v && busy_pre;
    if (v && !busy_pre) begin
      for (int k = 0; k < 2; k++) begin
        case (op)
          2'd0: wa[k] = int'(arg);
          2'd1: begin
            if (wa[k] < dep(k)) mem_m[k][wa[k]] = arg;
            if (AutoInc) wa[k] = adv(wa[k], dep(k));
          end
          2'd2: ra[k] = int'(arg);
          default: begin
            for (int i = 0; i <= int'(arg); i++) begin
              it.stamp = e + i;
              it.data  = (ra[k] < dep(k)) ? mem_m[k][ra[k]] : 8'h00;
              sb_q[k].push_back(it);
              if (AutoInc) ra[k] = adv(ra[k], dep(k));
            end
          end
        endcase
      end
      if (op == 2'd3 && arg != 8'd0) begin
        b_s = e;
        b_e = e + int'(arg);
      end
    end
    exp_busy = (e >= b_s) && (e < b_e);
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [7:0] arg);
    rx_valid = v;
    din      = {op, arg};
    @(posedge clk);
    #1;
    model_edge(v, op, arg);
  endtask

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: every negedge, plus an on-demand probe for the asynchronous reset check.
  always @(negedge clk or posedge probe) begin : mon
    exp_t it;
    bit   exp_tv;
    if (!done) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy", k, int'(busy_w[k]), int'(exp_busy));
        chk("cmd_drop", k, int'(drop_w[k]), int'(exp_drop));
        exp_tv = (sb_q[k].size() != 0) && (sb_q[k][0].stamp <= cyc);
        chk("tx_valid", k, int'(txv_w[k]), int'(exp_tv));
        if (exp_tv) begin
          it = sb_q[k].pop_front();
          if (txv_w[k]) chk("dout", k, int'(dout_w[k]), int'(it.data));
        end
        if (exp_rst) chk("dout_rst", k, int'(dout_w[k]), 0);
      end
    end else if (!finished) begin
      for (int k = 0; k < 2; k++) chk("sb_left", k, sb_q[k].size(), 0);
      finished = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
    end
  end

  initial begin
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    din      = '0;
    wa       = '{0, 0};
    ra       = '{0, 0};
    #2 rst_n = 1'b0;
    exp_rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rst  = 1'b0;

    // Give every location a known value, one address per write.
    for (int a = 0; a < 256; a++) begin
      step(1'b1, 2'd0, 8'(a));
      step(1'b1, 2'd1, 8'($urandom_range(0, 255)));
    end

    // Two-word burst after sequential writes.
    step(1, 0, 8'h10); step(1, 1, 8'hA5); step(1, 1, 8'h5A);
    step(1, 2, 8'h10); step(1, 3, 8'h01); step(0, 0, 0); step(0, 0, 0);
    // Address wrap at the top of memory.
    step(1, 0, 8'hFF); step(1, 1, 8'h11); step(1, 1, 8'h22);
    step(1, 2, 8'hFF); step(1, 3, 8'h01); step(0, 0, 0); step(0, 0, 0);
    // Command during a burst is dropped; memory stays unchanged.
    step(1, 0, 8'h40); step(1, 2, 8'h40); step(1, 3, 8'h03);
    step(0, 0, 0); step(1, 1, 8'h77); step(0, 0, 0); step(0, 0, 0);
    step(1, 2, 8'h40); step(1, 3, 8'h00); step(0, 0, 0);
    // Repeated address without auto-increment.
    step(1, 0, 8'h04); step(1, 1, 8'h33); step(1, 1, 8'h44);
    step(1, 2, 8'h04); step(1, 3, 8'h02); repeat (3) step(0, 0, 0);
    // Beyond the depth of the 200-word instance.
    step(1, 0, 8'hC8); step(1, 1, 8'h9C); step(1, 2, 8'hC8); step(1, 3, 8'h00);
    step(1, 2, 8'hC6); step(1, 3, 8'h03); repeat (3) step(0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      logic [7:0] arg;
      op  = 2'($urandom_range(0, 3));
      arg = (op == 2'd3) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      if (op != 2'd3 && $urandom_range(0, 3) == 0) arg = 8'($urandom_range(196, 201));
      step($urandom_range(0, 9) != 0, op, arg);
    end
    repeat (8) step(0, 0, 0);

    // Reset in the middle of an 8-word burst, after the third word.
    step(1, 2, 8'h20); step(1, 3, 8'h07); step(0, 0, 0); step(0, 0, 0);
    #5;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      while (sb_q[k].size() != 0 && sb_q[k][sb_q[k].size() - 1].stamp > cyc)
        void'(sb_q[k].pop_back());
      wa[k] = 0;
      ra[k] = 0;
    end
    b_s = 0;
    b_e = 0;
    exp_busy = 1'b0;
    exp_drop = 1'b0;
    exp_rst  = 1'b1;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_rst  = 1'b0;
    repeat (6) step(0, 0, 0);
    // Commands are accepted straight after reset release.
    step(1, 3, 8'h01);
    repeat (4) step(0, 0, 0);
    done = 1'b1;
  end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width in bits; ADDR_SIZE <= MEM_WIDTH.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of words; MEM_DEPTH <= 2**ADDR_SIZE.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port din  input  MEM_WIDTH+2  command word: din[MEM_WIDTH+1:MEM_WIDTH] opcode, din[MEM_WIDTH-1:0] payload.
REQ-007 SHALL have port rx_valid  input  1  din valid this cycle.
REQ-008 SHALL have port dout  output  MEM_WIDTH  read data, registered.
REQ-009 SHALL have port tx_valid  output  1  dout valid, one-cycle pulse per word.
REQ-010 SHALL have port busy  output  1  high while a burst read is in progress.
REQ-011 SHALL have port cmd_drop  output  1  one-cycle pulse when a command is discarded.

Function
REQ-012 SHALL sample a command on a rising edge where rx_valid=1 and busy=0.
REQ-013 SHALL on opcode 00 load write address waddr <= payload[ADDR_SIZE-1:0].
REQ-014 SHALL on opcode 01 write payload to mem[waddr] on that edge, then advance waddr by 1.
REQ-015 SHALL on opcode 10 load read address raddr <= payload[ADDR_SIZE-1:0].
REQ-016 SHALL on opcode 11 start a read of N+1 words, N = payload[ADDR_SIZE-1:0] (0..2**ADDR_SIZE-1).
REQ-017 SHALL present word 0 (mem[raddr]) on dout with tx_valid=1 at the same edge that samples opcode 11 (zero extra latency).
REQ-018 SHALL, if N>0, enter state BURST with remaining count N and busy=1 from that edge.
REQ-019 SHALL in BURST output one word per cycle, tx_valid=1 each cycle, advancing raddr after each word, for N further cycles.
REQ-020 SHALL return to IDLE and drop busy on the edge that outputs the last word.
REQ-021 SHALL hold tx_valid=0 on every edge that does not output a word; dout holds its last value.
REQ-022 SHALL ignore din when rx_valid=0.
REQ-023 SHALL discard any rx_valid=1 command while busy=1 and pulse cmd_drop for one cycle; no state change.
REQ-024 SHALL wrap waddr and raddr from MEM_DEPTH-1 to 0 when advancing.
REQ-025 SHALL discard writes when waddr >= MEM_DEPTH and return 0 for reads when raddr >= MEM_DEPTH; address still advances/wraps.
REQ-026 SHALL implement FSM states IDLE and BURST only; IDLE->BURST on opcode 11 with N>0; BURST->IDLE when count reaches last word or reset.
REQ-027 SHALL not reset memory contents.

Reset
REQ-028 SHALL on rst_n=0, immediately and without clk: dout=0, tx_valid=0, busy=0, cmd_drop=0, waddr=0, raddr=0, count=0, FSM=IDLE.
REQ-029 SHALL abort a burst on reset mid-operation; no further tx_valid after deassertion until a new opcode 11.
REQ-030 SHALL accept commands from the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL with macro SPI_RAM_AUTOINC_EN defined advance waddr after each write and raddr after each read word as in REQ-014/019.
REQ-032 SHALL without SPI_RAM_AUTOINC_EN keep waddr and raddr unchanged after access; a burst then repeats mem[raddr] N+1 times.

Verification
REQ-033 SHALL test: reset, 00/0x10, 01/0xA5, 01/0x5A, 10/0x10, 11/0x01 -> dout 0xA5 then 0x5A on consecutive cycles, tx_valid high 2 cycles, busy high 1 cycle.
REQ-034 SHALL test: 00/0xFF, 01/0x11, 01/0x22 -> mem[255]=0x11, mem[0]=0x22 (wrap); read burst from 0xFF, N=1 returns 0x11, 0x22.
REQ-035 SHALL test: burst N=3 with rx_valid=1 opcode 01 during cycle 2 -> cmd_drop pulse 1 cycle, memory unchanged, 4 words delivered.
REQ-036 SHALL test: burst N=7, assert rst_n=0 mid-cycle after 3rd word -> dout=0, tx_valid=0, busy=0 asynchronously; no words after release.
REQ-037 SHALL test: without SPI_RAM_AUTOINC_EN, 00/0x04, 01/0x33, 01/0x44, 10/0x04, 11/0x02 -> dout 0x44 three times.
REQ-038 SHALL test: MEM_DEPTH=200, write to 0xC8 then read 0xC8 -> dout 0x00, tx_valid=1.
